ram_n: RTL

//  Parametrised single-port word RAM. It generalises the fixed 8 x 16-bit ram8 to any width and depth.

---
 rtl/ram_n_pkg.sv | 6 +
 rtl/ram_n_clear_seq.sv | 34 +++
 rtl/ram_n.sv | 52 +++++
 3 files changed

// File: rtl/ram_n_pkg.sv
// ram_n_pkg: shared clear-sequencer state encodings and default word width for the ram_n family.
package ram_n_pkg;
    localparam logic ST_IDLE       = 1'b0;
    localparam logic ST_SWEEP      = 1'b1;
    localparam int   DEFAULT_WIDTH = 16;
endpackage

// File: rtl/ram_n_clear_seq.sv
// ram_n_clear_seq: zero-fill sweep sequencer; owns state, sweep pointer and busy.
module ram_n_clear_seq
    import ram_n_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clear_i,
    output logic              wr_en_sweep_o,
    output logic [ADDR_W-1:0] ptr_o,
    output logic              busy_o
);
    logic              state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    // the last word and the return to IDLE share one edge; the pointer then rolls back to 0
    always_comb begin
        state_d = (state_q == ST_SWEEP) ? ((ptr_q == '1) ? ST_IDLE : ST_SWEEP)
                                        : (clear_i ? ST_SWEEP : ST_IDLE);
        ptr_d   = (state_q == ST_SWEEP) ? ptr_q + 1'b1 : '0;
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_SWEEP;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end
    assign wr_en_sweep_o = (state_q == ST_SWEEP);
    assign ptr_o         = ptr_q;
    assign busy_o        = (state_q == ST_SWEEP);
endmodule

// File: rtl/ram_n.sv
// ram_n: parametrised single-port word RAM with hardware zero-fill sweep, busy flag and optional registered read.
module ram_n
    import ram_n_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int ADDR_W  = 3,
    parameter bit REG_OUT = 1'b0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [WIDTH-1:0]  in_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              load_i,
    input  logic              clear_i,
    output logic [WIDTH-1:0]  out_o,
    output logic              busy_o
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic [WIDTH-1:0]  mem [0:DEPTH-1];
    logic              wr_en_sweep;
    logic [ADDR_W-1:0] ptr;
    logic [WIDTH-1:0]  rd_data;
    ram_n_clear_seq #(.ADDR_W(ADDR_W)) u_seq (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .clear_i       (clear_i),
        .wr_en_sweep_o (wr_en_sweep),
        .ptr_o         (ptr),
        .busy_o        (busy_o)
    );
    // a clear in IDLE drops any simultaneous user write
    always_ff @(posedge clk_i) begin
        if (wr_en_sweep)
            mem[ptr] <= '0;
        else if (load_i && !clear_i)
            mem[addr_i] <= in_i;
    end
    assign rd_data = mem[addr_i];
    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] out_q, out_d;
        assign out_d = busy_o ? '0 : rd_data;
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i)
                out_q <= '0;
            else
                out_q <= out_d;
        end
        assign out_o = busy_o ? '0 : out_q;
    end else begin : g_comb
        assign out_o = busy_o ? '0 : rd_data;
    end
endmodule
